// File: rtl/anthem_msg_sequencer.sv
// Round-robin word sequencer: fetches space-terminated words from the character ROM and paces them to the display.
// Optional build macro SEQ_EMIT_TERM_EN: present the terminator byte as a final character before completing.
module anthem_msg_sequencer #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter logic [7:0]  TERM     = 8'h20,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned CHAR_GAP = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [7:0]             rom_data,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        gap_q, gap_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              last_char;
`ifdef SEQ_EMIT_TERM_EN
    logic              term_q, term_d;
`endif

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % NREQ);
    endfunction

    // First requester at or above the rr pointer, wrapping around.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[wrap_idx(32'(rr_q) + i)]) begin
                found  = 1'b1;
                winner = wrap_idx(32'(rr_q) + i);
            end
        end
    end

    always_comb begin
`ifdef SEQ_EMIT_TERM_EN
        last_char = (count_q == 8'(MAX_LEN - 1)) || term_q;
`else
        last_char = (count_q == 8'(MAX_LEN - 1));
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        rom_addr_d  = rom_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        gap_d       = gap_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
`ifdef SEQ_EMIT_TERM_EN
        term_d      = term_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d    = NREQ'(1) << winner;
                    owner_d    = winner;
                    rom_addr_d = req_addr[winner*ADDR_W +: ADDR_W];
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
`ifdef SEQ_EMIT_TERM_EN
                out_data_d  = rom_data;
                out_valid_d = 1'b1;
                term_d      = (rom_data == TERM);
                state_d     = S_PRESENT;
`else
                if (rom_data == TERM) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = S_DONE;
                end else begin
                    out_data_d  = rom_data;
                    out_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end
`endif
            end
            S_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q + 8'd1;
                    rom_addr_d  = rom_addr_q + ADDR_W'(1);
                    if (last_char) begin
                        done_d  = grant_q;
                        grant_d = '0;
                        state_d = S_DONE;
                    end else if (CHAR_GAP == 0) begin
                        state_d = S_WAIT;
                    end else begin
                        gap_d   = 8'(CHAR_GAP);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                rr_d    = wrap_idx(32'(owner_q) + 1);
                count_d = '0;
`ifdef SEQ_EMIT_TERM_EN
                term_d  = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            rom_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
            gap_q       <= '0;
            rr_q        <= '0;
            owner_q     <= '0;
`ifdef SEQ_EMIT_TERM_EN
            term_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            rom_addr_q  <= rom_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
`ifdef SEQ_EMIT_TERM_EN
            term_q      <= term_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: doc/anthem_msg_sequencer.md
Name: anthem_msg_sequencer

Overview:
- Sequences playback of space-terminated words from the shared 256-byte character ROM to the 7-segment output driver.
- Up to NREQ requesters each present a start address and request playback.
- A round-robin arbiter grants one requester at a time. The block then fetches characters (1-cycle ROM latency), paces them, and hands them off over a valid/ready interface.
- Sits between the input-switch/requester logic and the character ROM plus display register.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 8, ROM address width; addresses wrap modulo 2^ADDR_W.
- TERM, 8'h20, word terminator byte.
- MAX_LEN, 16, maximum characters emitted per grant (1..255).
- CHAR_GAP, 3, idle cycles inserted after each accepted character (0 = back-to-back).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- req  in  NREQ  level request per requester; hold until matching done pulse.
- req_addr  in  NREQ*ADDR_W  start address, requester i in bits [i*ADDR_W +: ADDR_W].
- grant  out  NREQ  one-hot; current owner, held from grant until done.
- done  out  NREQ  one-cycle pulse on owner's bit when its word completes.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_data  in  8  ROM data, valid the cycle after rom_addr changes.
- out_data  out  8  character to display.
- out_valid  out  1  out_data valid.
- out_ready  in  1  display accepts out_data when out_valid & out_ready.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0): grant=0, done=0, rom_addr=0, out_data=0, out_valid=0, busy=0, state=IDLE, rr pointer=0, char count=0, gap counter=0.
- States: IDLE, WAIT, PRESENT, GAP, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr pointer, wrapping.
  - Register grant and set rom_addr=req_addr[winner].
  - Go to WAIT.
- WAIT:
  - rom_data is valid in this state.
  - If rom_data==TERM: go to DONE.
  - Otherwise: out_data<=rom_data, out_valid<=1, go to PRESENT.
- PRESENT:
  - Hold out_valid and out_data stable until out_ready.
  - On handshake: out_valid<=0, count++, rom_addr<=rom_addr+1 (wraps 255->0).
  - If count reaches MAX_LEN: go to DONE.
  - Else if CHAR_GAP==0: go to WAIT.
  - Else load gap counter with CHAR_GAP and go to GAP.
- GAP: decrement the gap counter; when it reaches 1, go to WAIT.
- DONE:
  - done[owner]=1 for exactly one cycle; grant cleared.
  - rr pointer <= owner+1 mod NREQ; count cleared; return to IDLE.
- Latency:
  - req high at IDLE edge t: grant is visible at t+1, first out_valid at t+2.
  - Character-to-character spacing with out_ready tied high: 2+CHAR_GAP cycles.
- A requester dropping req mid-word does not abort the word; the word completes and done still pulses.
- A req held high after done is re-arbitrated normally; it gets lowest priority for that round.
- A word starting at a TERM byte emits nothing; done pulses at t+2.
- Simultaneous requests: exactly one grant; the others wait in rr order; there is no starvation.
- req_addr is sampled only at grant.

Optional Feature:
- Macro SEQ_EMIT_TERM_EN.
- When defined: a TERM byte read in WAIT is presented as a normal character (handshaked, counts toward MAX_LEN), then the FSM goes to DONE after acceptance.
- When undefined: TERM is never emitted (behaviour above).

Test Plan:
1. Single word: ROM[0..5]="Fuego ", req[0]=1, req_addr0=0, out_ready=1, CHAR_GAP=3.
   -> out_data sequence 0x46,0x75,0x65,0x67,0x6F, one every 5 cycles; done[0] pulse after the last; no 0x20 emitted.
2. Round-robin: req=4'b0101 held, words at 0x00 and 0x10.
   -> grant order req0, req2, req0, req2; done pulses alternate.
3. Backpressure: out_ready=0 for 10 cycles mid-word.
   -> out_valid and out_data held constant; no character lost or duplicated after out_ready=1.
4. Boundaries:
   - Start 0xFE with ROM[0xFE]=0x41, ROM[0xFF]=0x42, ROM[0x00]=0x20 -> emits 0x41,0x42 (addr wraps), then done.
   - A word of 20 non-TERM bytes -> exactly 16 characters, then done.
5. Reset mid-word: rst_n low during PRESENT.
   -> all outputs 0 immediately; after release, req1 is serviced from its start address.
6. With SEQ_EMIT_TERM_EN, scenario 1 -> six characters ending with 0x20, then done[0].
